psk_symbol_decoder: RTL

Consumes the per-window phase-match bitmask and strobe from the PSK correlator dispatcher. Each strobe is reduced to one of six code phases, consecutive phases are differentially decoded into bits, and the block hunts for a sync word. After lock it assembles LSB-first bytes and presents them on a valid/ready output with a one-entry holding register.

---
 rtl/psk_pkg.sv | 26 ++
 rtl/psk_phase_pick.sv | 32 +++
 rtl/psk_symbol_decoder.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/psk_pkg.sv
// Shared types and constants for the PSK symbol decoder: phase index type,
// framing FSM states and the modular phase-difference helper.
package psk_pkg;

    localparam int PHASES = 6;

    typedef logic [2:0] phase_t;

    typedef enum logic {
        HUNT = 1'b0,
        SYNC = 1'b1
    } state_t;

    localparam logic [7:0] SYNC_WORD_DEFAULT = 8'hA5;

    // (a - b) mod PHASES for operands already in 0..PHASES-1.
    function automatic phase_t phase_diff(input phase_t a, input phase_t b);
        logic [3:0] t;
        t = {1'b0, a} + 4'(PHASES) - {1'b0, b};
        if (t >= 4'(PHASES)) begin
            t = t - 4'(PHASES);
        end
        return t[2:0];
    endfunction

endpackage

// File: rtl/psk_phase_pick.sv
// Combinational circular run-start finder: maps a 6-bit phase-match mask to
// the index where its run of ones begins, or flags the mask as an erasure.
module psk_phase_pick
    import psk_pkg::*;
(
    input  logic [5:0] m,
    output phase_t     phase,
    output logic       erase
);

    logic [PHASES-1:0] run_start;

    // A run starts at i when bit i is set and its circular predecessor is clear.
    generate
        for (genvar gi = 0; gi < PHASES; gi++) begin : g_run_start
            assign run_start[gi] = m[gi] & ~m[(gi + PHASES - 1) % PHASES];
        end
    endgenerate

    always_comb begin
        phase = '0;
        for (int i = PHASES - 1; i >= 0; i--) begin
            if (run_start[i]) begin
                phase = 3'(i);
            end
        end
    end

    // All-clear and all-set masks carry no run boundary.
    assign erase = (m == 6'h00) || (m == 6'h3F);

endmodule

// File: rtl/psk_symbol_decoder.sv
// Differential PSK symbol decoder: phase pick and bit decision (stage 1),
// sync hunt, byte assembly and a one-entry valid/ready holding register (stage 2).
module psk_symbol_decoder
    import psk_pkg::*;
#(
    parameter logic [7:0] SYNC_WORD   = SYNC_WORD_DEFAULT,
    parameter int         ERASE_LIMIT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] value,
    input  logic       stb,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       locked,
    output logic       erasure,
    output logic       overrun
);

    localparam logic [3:0] ERASE_LIMIT_W = 4'(ERASE_LIMIT);

    // Stage 1: phase pick and differential bit decision
    phase_t pick_phase;
    logic   pick_erase;
    phase_t sym_diff;
    logic   bit_next;
    logic   unused_value_hi;

    logic   ref_vld_reg;
    phase_t ref_phase_reg;
    logic   s1_sym_reg;
    logic   s1_erase_reg;
    logic   s1_bit_vld_reg;
    logic   s1_bit_reg;

    psk_phase_pick u_phase_pick (
        .m     (value[5:0]),
        .phase (pick_phase),
        .erase (pick_erase)
    );

    assign unused_value_hi = ^value[7:6];

    assign sym_diff = phase_diff(pick_phase, ref_phase_reg);
    assign bit_next = (sym_diff >= 3'd2) && (sym_diff <= 3'd4);

    always_ff @(posedge clk) begin
        if (rst) begin
            ref_vld_reg    <= 1'b0;
            ref_phase_reg  <= '0;
            s1_sym_reg     <= 1'b0;
            s1_erase_reg   <= 1'b0;
            s1_bit_vld_reg <= 1'b0;
            s1_bit_reg     <= 1'b0;
        end else begin
            s1_sym_reg     <= stb & ~pick_erase;
            s1_erase_reg   <= stb & pick_erase;
            // The first valid symbol after reset or an erasure only seeds the reference.
            s1_bit_vld_reg <= stb & ~pick_erase & ref_vld_reg;
            s1_bit_reg     <= bit_next;
            if (stb) begin
                if (pick_erase) begin
                    ref_vld_reg <= 1'b0;
                end else begin
                    ref_vld_reg   <= 1'b1;
                    ref_phase_reg <= pick_phase;
                end
            end
        end
    end

    assign erasure = s1_erase_reg;

    // Stage 2: framing FSM and byte assembly
    state_t     state_reg;
    logic [7:0] sreg_reg;
    logic [7:0] asm_reg;
    logic [2:0] bitcnt_reg;
    logic [3:0] erase_cnt_reg;
    logic       locked_reg;

    logic [7:0] sreg_next;
    logic [7:0] asm_next;
    logic       byte_done;
    logic       erase_hit;

    assign sreg_next = {s1_bit_reg, sreg_reg[7:1]};
    assign asm_next  = {s1_bit_reg, asm_reg[7:1]};
    assign byte_done = (state_reg == SYNC) && s1_bit_vld_reg && (bitcnt_reg == 3'd7);
    assign erase_hit = (erase_cnt_reg + 4'd1) >= ERASE_LIMIT_W;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= HUNT;
            sreg_reg      <= '0;
            asm_reg       <= '0;
            bitcnt_reg    <= '0;
            erase_cnt_reg <= '0;
            locked_reg    <= 1'b0;
        end else begin
            case (state_reg)
                HUNT: begin
                    erase_cnt_reg <= '0;
                    if (s1_erase_reg) begin
                        sreg_reg <= '0;
                    end else if (s1_bit_vld_reg) begin
                        sreg_reg <= sreg_next;
                        if (sreg_next == SYNC_WORD) begin
                            state_reg  <= SYNC;
                            locked_reg <= 1'b1;
                            bitcnt_reg <= '0;
                            asm_reg    <= '0;
                        end
                    end
                end
                SYNC: begin
                    if (s1_erase_reg) begin
                        if (erase_hit) begin
                            state_reg     <= HUNT;
                            locked_reg    <= 1'b0;
                            sreg_reg      <= '0;
                            asm_reg       <= '0;
                            bitcnt_reg    <= '0;
                            erase_cnt_reg <= '0;
                        end else begin
                            erase_cnt_reg <= erase_cnt_reg + 4'd1;
                        end
                    end else if (s1_sym_reg) begin
                        erase_cnt_reg <= '0;
                        if (s1_bit_vld_reg) begin
                            // bitcnt wraps 7 -> 0 on the byte-completing bit.
                            asm_reg    <= asm_next;
                            bitcnt_reg <= bitcnt_reg + 3'd1;
                        end
                    end
                end
                default: begin
                    state_reg  <= HUNT;
                    locked_reg <= 1'b0;
                end
            endcase
        end
    end

    assign locked = locked_reg;

    // One-entry output holding register
    logic [7:0] byte_data_reg;
    logic       byte_valid_reg;
    logic       overrun_reg;
    logic       xfer;

    assign xfer = byte_valid_reg & byte_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_data_reg  <= '0;
            byte_valid_reg <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            overrun_reg <= 1'b0;
            if (byte_done && (!byte_valid_reg || xfer)) begin
                byte_data_reg  <= asm_next;
                byte_valid_reg <= 1'b1;
            end else if (byte_done) begin
                overrun_reg <= 1'b1;
            end else if (xfer) begin
                byte_valid_reg <= 1'b0;
            end
        end
    end

    assign byte_data  = byte_data_reg;
    assign byte_valid = byte_valid_reg;
    assign overrun    = overrun_reg;

endmodule
